fetch_unit_s: RTL and testbench

- Instruction-fetch initiator for the synchronous instruction ROM (10-bit word address in, 32-bit instruction out, one-cycle registered read).
- Owns the PC and issues word reads to the ROM. Tags each in-flight read and buffers returned instructions in a small FIFO.
- Presents {pc, instr} to the decode stage over a valid/ready handshake.
- Handles branch/jump redirects by squashing stale reads.

---
 rtl/fetch_unit_s_pkg.sv | 25 ++
 rtl/fetch_buf_s.sv | 106 ++++++++++
 rtl/fetch_unit_s.sv | 150 +++++++++++++++
 tb/tb_fetch_unit_s.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_s_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_s_pkg
// Shared constants and types for the instruction-fetch unit.
//   NOP_INSTR     : canonical no-op encoding (addi x0,x0,0)
//   WORD_BYTES    : PC increment per fetched instruction word
//   fetch_entry_t : {pc, instr} pair carried through the fetch buffer
//   fetch_state_t : observability FSM states of the fetch unit
// ---------------------------------------------------------------------------
package fetch_unit_s_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf_s.sv
// ---------------------------------------------------------------------------
// fetch_buf_s
// Small synchronous FIFO of fetch_entry_t. Slot 0 is always the head, so the
// head is a plain register that directly drives the consumer. When the last
// entry is popped the slot is left untouched, so the head keeps its last value
// while the buffer is empty.
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous reset, active-low
//   push_i      in   write din_i at the tail
//   pop_i       in   consume the head (ignored when empty)
//   flush_i     in   drop all entries (wins over push)
//   din_i       in   entry to write
//   occupancy_o out  number of valid entries
//   head_o      out  head entry
//   empty_o     out  no valid entries
//   full_o      out  DEPTH valid entries
// ---------------------------------------------------------------------------
module fetch_buf_s
    import fetch_unit_s_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     din_i,
    output logic [CNT_W-1:0] occupancy_o,
    output fetch_entry_t     head_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             pop_eff;
    logic             push_eff;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign occupancy_o = count_q;

    assign pop_eff  = pop_i & ~empty_o;
    assign push_eff = push_i & (~full_o | pop_eff);
    // After a pop the tail position moves down by one.
    assign wr_idx   = count_q - CNT_W'(pop_eff);

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        fetch_entry_t slot_q;
        fetch_entry_t slot_d;

        if (gi < DEPTH - 1) begin : g_shift
            always_comb begin
                slot_d = slot_q;
                if (!flush_i) begin
                    if (push_eff && wr_idx == CNT_W'(gi)) begin
                        slot_d = din_i;
                    end else if (pop_eff && count_q > CNT_W'(gi + 1)) begin
                        slot_d = g_slot[gi + 1].slot_q;
                    end
                end
            end
        end else begin : g_last
            always_comb begin
                slot_d = slot_q;
                if (!flush_i && push_eff && wr_idx == CNT_W'(gi)) begin
                    slot_d = din_i;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end
    end

    assign head_o = g_slot[0].slot_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit_s.sv
// ---------------------------------------------------------------------------
// fetch_unit_s
// Instruction-fetch initiator for a synchronous ROM with a one-cycle read.
// Owns the PC, issues one word read per cycle when the buffer has room for
// the result, tags each read with an epoch and drops responses whose epoch
// was invalidated by a redirect. Results are presented as {pc, instr} over a
// valid/ready handshake.
// Ports:
//   clk             in   clock
//   rst_n           in   synchronous reset, active-low
//   rom_addr        out  ROM word address (pc_fetch[ADDR_W+1:2])
//   rom_instr       in   ROM data, one cycle after rom_addr
//   redirect_valid  in   taken branch/jump this cycle
//   redirect_target in   new PC
//   out_valid       out  head instruction available
//   out_ready       in   decode accepts head
//   out_instr       out  head instruction
//   out_pc          out  PC of head instruction
//   misalign_err    out  sticky: a non-word-aligned redirect was seen
// ---------------------------------------------------------------------------
module fetch_unit_s
    import fetch_unit_s_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 10,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              misalign_err
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [31:0]     pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic            resp_epoch_q, resp_epoch_d;
    logic            epoch_q, epoch_d;
    logic            misalign_q, misalign_d;
    fetch_state_t    state_q, state_d;

    logic            redirect_ok;
    logic            redirect_bad;
    logic            accept;
    logic            issue;
    logic            push;
    logic [CNT_W:0]  demand;
    logic [CNT_W-1:0] occupancy;
    logic            buf_empty;
    logic            buf_full;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // A misaligned target is ignored completely apart from raising the flag.
    assign redirect_ok  = redirect_valid & (redirect_target[1:0] == 2'b00);
    assign redirect_bad = redirect_valid & (redirect_target[1:0] != 2'b00);

    assign accept = out_valid & out_ready;

    // Slots that will be claimed after this cycle: buffered plus the read
    // returning next cycle, minus the entry leaving now.
    assign demand = {1'b0, occupancy} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(accept);
    assign issue  = ~redirect_ok & (demand < (CNT_W + 1)'(BUF_DEPTH));

    // A response returning while a redirect happens is stale as well.
    assign push       = inflight_q & (resp_epoch_q == epoch_q) & ~redirect_ok;
    assign push_entry = '{pc: resp_pc_q, instr: rom_instr};

    assign rom_addr = pc_q[ADDR_W+1:2];

    always_comb begin
        pc_d         = pc_q;
        inflight_d   = issue;
        resp_pc_d    = resp_pc_q;
        resp_epoch_d = resp_epoch_q;
        epoch_d      = epoch_q;
        misalign_d   = misalign_q | redirect_bad;
        if (redirect_ok) begin
            pc_d    = redirect_target;
            epoch_d = ~epoch_q;
        end else if (issue) begin
            pc_d         = pc_q + WORD_BYTES;
            resp_pc_d    = pc_q;
            resp_epoch_d = epoch_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:  state_d = redirect_ok ? ST_FLUSH : ST_RUN;
            ST_RUN:   state_d = redirect_ok ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = redirect_ok ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= {RESET_PC[31:2], 2'b00};
            inflight_q   <= 1'b0;
            resp_pc_q    <= '0;
            resp_epoch_q <= 1'b0;
            epoch_q      <= 1'b0;
            misalign_q   <= 1'b0;
            state_q      <= ST_BOOT;
        end else begin
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            resp_pc_q    <= resp_pc_d;
            resp_epoch_q <= resp_epoch_d;
            epoch_q      <= epoch_d;
            misalign_q   <= misalign_d;
            state_q      <= state_d;
        end
    end

    fetch_buf_s #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (accept),
        .flush_i     (redirect_ok),
        .din_i       (push_entry),
        .occupancy_o (occupancy),
        .head_o      (head),
        .empty_o     (buf_empty),
        .full_o      (buf_full)
    );

    assign out_valid    = ~buf_empty;
    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign misalign_err = misalign_q;

    a_no_issue_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue && buf_full && !accept));

endmodule

// File: tb/tb_fetch_unit_s.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit_s
// Directed bench for fetch_unit_s. Two instances: dut (RESET_PC=0) exercises
// streaming, stall, redirects and misaligned redirects; dut_w (RESET_PC=0xFF8)
// exercises ROM address wrap. Each ROM returns instr = word_address*4.
// ---------------------------------------------------------------------------
module tb_fetch_unit_s;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [9:0]  rom_addr;
    logic [31:0] rom_instr = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    logic [9:0]  rom_addr_w;
    logic [31:0] rom_instr_w = '0;
    logic        redirect_valid_w = 1'b0;
    logic [31:0] redirect_target_w = '0;
    logic        out_valid_w;
    logic        out_ready_w = 1'b1;
    logic [31:0] out_instr_w;
    logic [31:0] out_pc_w;
    logic        misalign_err_w;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fetch_unit_s #(
        .RESET_PC  (32'h0000_0000),
        .ADDR_W    (10),
        .BUF_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_addr        (rom_addr),
        .rom_instr       (rom_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .misalign_err    (misalign_err)
    );

    fetch_unit_s #(
        .RESET_PC  (32'h0000_0FF8),
        .ADDR_W    (10),
        .BUF_DEPTH (2)
    ) dut_w (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_addr        (rom_addr_w),
        .rom_instr       (rom_instr_w),
        .redirect_valid  (redirect_valid_w),
        .redirect_target (redirect_target_w),
        .out_valid       (out_valid_w),
        .out_ready       (out_ready_w),
        .out_instr       (out_instr_w),
        .out_pc          (out_pc_w),
        .misalign_err    (misalign_err_w)
    );

    // Synchronous ROMs, one-cycle registered read.
    always @(posedge clk) begin
        rom_instr   <= {20'd0, rom_addr, 2'b00};
        rom_instr_w <= {20'd0, rom_addr_w, 2'b00};
    end

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return {20'd0, pc[11:2], 2'b00};
    endfunction

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_pc_w;
        logic        exp_v;
        logic [9:0]  exp_ra;

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk_vec("rst_valid",    32'(out_valid), 32'd0);
        chk_vec("rst_pc",       out_pc, 32'd0);
        chk_vec("rst_instr",    out_instr, 32'd0);
        chk_vec("rst_misalign", 32'(misalign_err), 32'd0);
        chk_vec("rst_rom_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;

        // ---------------- stream / stall / redirects / misalign ----------------
        exp_pc = 32'h0;
        for (int c = 0; c < 50; c++) begin
            out_ready       = !(c >= 5 && c <= 9);
            redirect_valid  = 1'b0;
            redirect_target = 32'h0;
            case (c)
                20: begin redirect_valid = 1'b1; redirect_target = 32'h0000_0100; end
                28: begin redirect_valid = 1'b1; redirect_target = 32'h0000_0200; end
                29: begin redirect_valid = 1'b1; redirect_target = 32'h0000_0300; end
                40: begin redirect_valid = 1'b1; redirect_target = 32'h0000_0102; end
                default: ;
            endcase

            exp_v = !(c == 0 || c == 1 || c == 21 || c == 22 ||
                      c == 29 || c == 30 || c == 31);
            chk_vec($sformatf("valid_c%0d", c), 32'(out_valid), 32'(exp_v));

            if (out_valid && out_ready) begin
                chk_vec($sformatf("pc_c%0d", c), out_pc, exp_pc);
                chk_vec($sformatf("instr_c%0d", c), out_instr, rom_word(exp_pc));
                $display("cyc %0d: accept pc=%h instr=%h", c, out_pc, out_instr);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid && redirect_target[1:0] == 2'b00) begin
                exp_pc = redirect_target;
            end

            case (c)
                1:  chk_vec("rom_addr_c1", 32'(rom_addr), 32'd1);
                7:  begin
                        chk_vec("stall_hold_pc", out_pc, 32'd12);
                        chk_vec("stall_rom_addr", 32'(rom_addr), 32'd5);
                    end
                21: chk_vec("redir_rom_addr", 32'(rom_addr), 32'd64);
                29: chk_vec("redir2_rom_addr", 32'(rom_addr), 32'd128);
                30: chk_vec("redir3_rom_addr", 32'(rom_addr), 32'd192);
                default: ;
            endcase
            chk_vec($sformatf("misalign_c%0d", c), 32'(misalign_err), 32'(c > 40));
            step();
        end

        // ---------------- reset mid-operation ----------------
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk_vec("rst2_valid",    32'(out_valid), 32'd0);
        chk_vec("rst2_pc",       out_pc, 32'd0);
        chk_vec("rst2_instr",    out_instr, 32'd0);
        chk_vec("rst2_misalign", 32'(misalign_err), 32'd0);
        chk_vec("rst2_valid_w",  32'(out_valid_w), 32'd0);
        rst_n = 1'b1;

        // ---------------- address wrap (dut_w) ----------------
        exp_pc_w = 32'h0000_0FF8;
        exp_ra   = 10'd1022;
        for (int c = 0; c < 8; c++) begin
            out_ready = 1'b1;
            chk_vec($sformatf("wrap_rom_addr_c%0d", c), 32'(rom_addr_w), 32'(exp_ra));
            chk_vec($sformatf("wrap_valid_c%0d", c), 32'(out_valid_w), 32'(c >= 2));
            if (c == 2) begin
                chk_vec("rst2_first_pc", out_pc, 32'd0);
            end
            if (out_valid_w) begin
                chk_vec($sformatf("wrap_pc_c%0d", c), out_pc_w, exp_pc_w);
                chk_vec($sformatf("wrap_instr_c%0d", c), out_instr_w, rom_word(exp_pc_w));
                $display("wrap cyc %0d: accept pc=%h instr=%h", c, out_pc_w, out_instr_w);
                exp_pc_w = exp_pc_w + 32'd4;
            end
            exp_ra = exp_ra + 10'd1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
